pipeline_ctrl: RTL

- Central sequencer for the 5-stage pipeline latches (IFID, IDEX, EXMEM, MEMWB) and the PC register.
- Each cycle it drives the per-latch enable/flush and the PC enable from these inputs: memory handshakes (ihit/dhit), load-use hazard, taken branch, jump and halt.
- A small FSM tracks outstanding data-memory waits and the terminal halted state.

---
 rtl/pipeline_ctrl_if.sv | 37 +++
 rtl/pipeline_ctrl.sv | 114 +++++++++++
 2 files changed

// File: rtl/pipeline_ctrl_if.sv
// Control bundle between the 5-stage datapath and its sequencer: hazard and memory
// status flowing in, latch/PC enables, flushes and the halted flag flowing out.
interface pipeline_ctrl_if;
   logic       ihit;
   logic       dhit;
   logic       dmem_req;
   logic       idex_dload;
   logic [4:0] idex_rt;
   logic [4:0] ifid_rs;
   logic [4:0] ifid_rt;
   logic       branch_taken;
   logic       jump;
   logic       halt_mem;

   logic       pc_en;
   logic       ifid_en;
   logic       idex_en;
   logic       exmem_en;
   logic       memwb_en;
   logic       ifid_flush;
   logic       idex_flush;
   logic       halted;

   // Sequencer side: consumes status, drives enables.
   modport master (
      input  ihit, dhit, dmem_req, idex_dload, idex_rt, ifid_rs, ifid_rt,
             branch_taken, jump, halt_mem,
      output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halted
   );

   // Datapath side: reports status, obeys enables.
   modport slave (
      output ihit, dhit, dmem_req, idex_dload, idex_rt, ifid_rs, ifid_rt,
             branch_taken, jump, halt_mem,
      input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halted
   );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: per-cycle latch/PC enables and flushes, data-memory wait and halt FSM.
// Define PIPE_PERF_EN to build the saturating stall/flush performance counters.
module pipeline_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic              CLK,
   input  logic              nRST,
   pipeline_ctrl_if.master   pif,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DWAIT = 2'd1,
      HALT  = 2'd2
   } state_t;

   state_t state, next_state;
   logic   load_use;
   logic   advance;

   assign load_use = pif.idex_dload & (pif.idex_rt != 5'd0) &
                     ((pif.idex_rt == pif.ifid_rs) | (pif.idex_rt == pif.ifid_rt));

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) state <= RUN;
      else       state <= next_state;
   end

   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      next_state     = state;
      advance        = 1'b0;
      pif.pc_en      = 1'b0;
      pif.ifid_en    = 1'b0;
      pif.idex_en    = 1'b0;
      pif.exmem_en   = 1'b0;
      pif.memwb_en   = 1'b0;
      pif.ifid_flush = 1'b0;
      pif.idex_flush = 1'b0;

      unique case (state)
         RUN: begin
            if (pif.halt_mem) begin
               // Let HALT retire into WB, then freeze everything.
               pif.memwb_en = 1'b1;
               next_state   = HALT;
            end else if (pif.dmem_req && !pif.dhit) begin
               next_state = DWAIT;
            end else begin
               advance = 1'b1;
            end
         end
         DWAIT: begin
            if (pif.dhit) begin
               advance    = 1'b1;
               next_state = RUN;
            end
         end
         HALT:    next_state = HALT;
         default: next_state = RUN;
      endcase

      if (advance) begin
         pif.pc_en    = 1'b1;
         pif.ifid_en  = 1'b1;
         pif.idex_en  = 1'b1;
         pif.exmem_en = 1'b1;
         pif.memwb_en = 1'b1;
         // A taken branch squashes the front end, so it outranks every other front-end hazard.
         if (pif.branch_taken) begin
            pif.ifid_flush = 1'b1;
            pif.idex_flush = 1'b1;
         end else if (load_use) begin
            pif.pc_en      = 1'b0;
            pif.ifid_en    = 1'b0;
            pif.idex_flush = 1'b1;
         end else if (pif.jump) begin
            pif.ifid_flush = 1'b1;
            pif.pc_en      = pif.ihit;
         end else if (!pif.ihit) begin
            pif.pc_en      = 1'b0;
            pif.ifid_flush = 1'b1;
         end
      end
   end

   assign pif.halted = (state == HALT);

`ifdef PIPE_PERF_EN
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] stall_q, flush_q;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (!pif.pc_en && (state != HALT) && (stall_q != '1)) stall_q <= stall_q + CNT_ONE;
         if ((pif.ifid_flush || pif.idex_flush) && (flush_q != '1)) flush_q <= flush_q + CNT_ONE;
      end
   end

   assign stall_cnt = stall_q;
   assign flush_cnt = flush_q;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule
